// File: rtl/xc_malu_mul_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// xc_malu_mul_seq_pkg : shared types for the multiply sequencer
// Rev 1.0
// ------------------------------------------------------------------
package xc_malu_mul_seq_pkg;

  localparam int MALU_STEPS = 32;
  localparam int COUNT_W    = 6;

  // Bit positions of the one-hot uop vector built by the sequencer.
  localparam int OP_IDX_MUL    = 0;
  localparam int OP_IDX_MULH   = 1;
  localparam int OP_IDX_MULHU  = 2;
  localparam int OP_IDX_MULHSU = 3;
  localparam int OP_IDX_CLMUL  = 4;
  localparam int OP_IDX_CLMULH = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHU  = 3'd2,
    OP_MULHSU = 3'd3,
    OP_CLMUL  = 3'd4,
    OP_CLMULH = 3'd5
  } op_t;

  // Resolves multiple set uop bits with mul taking highest priority.
  function automatic op_t op_decode(input logic [5:0] uops);
    if (uops[OP_IDX_MUL])         return OP_MUL;
    else if (uops[OP_IDX_MULH])   return OP_MULH;
    else if (uops[OP_IDX_MULHU])  return OP_MULHU;
    else if (uops[OP_IDX_MULHSU]) return OP_MULHSU;
    else if (uops[OP_IDX_CLMUL])  return OP_CLMUL;
    else                          return OP_CLMULH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xc_malu_mul_seq_padd32.sv
`default_nettype none
// ------------------------------------------------------------------
// xc_malu_padd32 : 32-bit packed adder with carry-enable gating
// Rev 1.0
// ------------------------------------------------------------------
module xc_malu_padd32 (
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        sub,
  input  logic        cin,
  input  logic        cen,
  output logic [32:0] cout,
  output logic [31:0] result
);

  logic [31:0] w_rhs_eff;
  logic        w_carry;

  assign w_rhs_eff = sub ? ~rhs : rhs;

  // With cen low every carry is killed, giving a bitwise XOR for carryless ops.
  always_comb begin
    w_carry = cin | sub;
    cout    = '0;
    result  = '0;
    for (int i = 0; i < 32; i++) begin
      result[i] = lhs[i] ^ w_rhs_eff[i] ^ w_carry;
      w_carry   = cen & ((lhs[i] & w_rhs_eff[i]) |
                         (lhs[i] & w_carry)      |
                         (w_rhs_eff[i] & w_carry));
      cout[i]   = w_carry;
    end
    cout[32] = cout[31];
  end

endmodule
`default_nettype wire

// File: rtl/xc_malu_mul_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// xc_malu_mul_seq : iteration sequencer for the multi-cycle multiplier
// Rev 1.0
// ------------------------------------------------------------------
module xc_malu_mul_seq
  import xc_malu_mul_seq_pkg::*;
#(
  parameter int STEPS = MALU_STEPS
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        uop_mul,
  input  logic        uop_mulh,
  input  logic        uop_mulhu,
  input  logic        uop_mulhsu,
  input  logic        uop_clmul,
  input  logic        uop_clmulh,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] step_rs1,
  output logic [31:0] step_rs2,
  output logic [5:0]  step_count,
  output logic [63:0] step_acc,
  output logic [31:0] step_arg_0,
  output logic        step_carryless,
  output logic        step_lhs_sign,
  output logic        step_rhs_sign,
  input  logic [31:0] step_padd_lhs,
  input  logic [31:0] step_padd_rhs,
  input  logic        step_padd_sub,
  input  logic        step_padd_cin,
  input  logic        step_padd_cen,
  output logic [32:0] step_padd_cout,
  output logic [31:0] step_padd_result,
  input  logic [63:0] step_n_acc,
  input  logic [31:0] step_n_arg_0,
  input  logic        step_ready
);

  localparam logic [COUNT_W-1:0] C_LAST = COUNT_W'(STEPS);

  state_t             r_state;
  op_t                r_op;
  logic [COUNT_W-1:0] r_count;
  logic [63:0]        r_acc;
  logic [31:0]        r_arg_0;
  logic [31:0]        r_rs1;
  logic [31:0]        r_rs2;

  logic [5:0] w_uops;
  logic       w_start;
  logic       w_hi;

  assign w_uops  = {uop_clmulh, uop_clmul, uop_mulhsu, uop_mulhu, uop_mulh, uop_mul};
  assign w_start = valid & ~flush & (|w_uops);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_count <= '0;
      r_acc   <= '0;
      r_arg_0 <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_op    <= op_decode(w_uops);
            r_count <= '0;
            r_acc   <= '0;
            r_arg_0 <= rs2;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
          end
        end
        ST_RUN: begin
          if (flush || step_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= step_n_acc;
            r_arg_0 <= step_n_arg_0;
            if (r_count != C_LAST) r_count <= r_count + COUNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Done comes from the count register; only flush may veto it in-cycle.
  assign done = (r_state == ST_RUN) & (r_count == C_LAST) & ~flush;

  assign w_hi   = r_op inside {OP_MULH, OP_MULHU, OP_MULHSU, OP_CLMULH};
  assign result = done ? (w_hi ? r_acc[63:32] : r_acc[31:0]) : 32'd0;

  assign step_rs1       = r_rs1;
  assign step_rs2       = r_rs2;
  assign step_count     = r_count;
  assign step_acc       = r_acc;
  assign step_arg_0     = r_arg_0;
  assign step_carryless = (r_op == OP_CLMUL) | (r_op == OP_CLMULH);
  assign step_lhs_sign  = (r_op == OP_MULH) | (r_op == OP_MULHSU);
  assign step_rhs_sign  = (r_op == OP_MULH);

  xc_malu_padd32 u_padd (
    .lhs    (step_padd_lhs),
    .rhs    (step_padd_rhs),
    .sub    (step_padd_sub),
    .cin    (step_padd_cin),
    .cen    (step_padd_cen),
    .cout   (step_padd_cout),
    .result (step_padd_result)
  );

endmodule
`default_nettype wire
